// File: rtl/dog_pkg.sv
// Shared constants and state encoding for the DoG frame stream transmitter.
package dog_pkg;

  localparam int          N         = 450;
  localparam int          M         = 600;
  localparam int          PIX_W     = 8;
  localparam logic [15:0] OFFSET    = 16'h8000;
  localparam int          FRAME_PIX = N * M;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STREAM    = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } dog_state_e;

endpackage

// File: rtl/dog_sub_stage.sv
// One DoG lane: registers a pixel pair, then registers (b - a) + OFFSET.
// Unsigned pixels are widened by one bit so the difference is exact in signed form.
module dog_sub_stage
  import dog_pkg::*;
#(
  parameter int          PIX_W  = dog_pkg::PIX_W,
  parameter logic [15:0] OFFSET = dog_pkg::OFFSET
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vld,
  input  logic [PIX_W-1:0] i_a,
  input  logic [PIX_W-1:0] i_b,
  output logic             o_vld_p1,
  output logic             o_vld_p2,
  output logic [15:0]      o_diff
);

  logic [PIX_W-1:0]        r_a_p1;
  logic [PIX_W-1:0]        r_b_p1;
  logic                    r_vld_p1;
  logic signed [PIX_W:0]   w_diff_p1;
  logic [15:0]             r_diff_p2;
  logic                    r_vld_p2;

  // Sign-extend the exact difference to 16 bits and bias it so unsigned order matches signed order.
  function automatic logic [15:0] bias_diff(input logic signed [PIX_W:0] d);
    logic signed [15:0] d_ext;
    d_ext = 16'(d);
    return d_ext + OFFSET;
  endfunction

  assign w_diff_p1 = $signed({1'b0, r_b_p1}) - $signed({1'b0, r_a_p1});

  // Stage 1: capture the operand pair when a pixel arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_p1   <= '0;
      r_b_p1   <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= i_vld;
      if (i_vld) begin
        r_a_p1 <= i_a;
        r_b_p1 <= i_b;
      end
    end
  end

  // Stage 2: register the biased difference; the output holds while no new sample arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff_p2 <= '0;
      r_vld_p2  <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_diff_p2 <= bias_diff(w_diff_p1);
      end
    end
  end

  assign o_vld_p1 = r_vld_p1;
  assign o_vld_p2 = r_vld_p2;
  assign o_diff   = r_diff_p2;

endmodule

// File: rtl/dog_stream_tx.sv
// DoG frame stream transmitter: four Gaussian planes in, three biased DoG planes out,
// exactly N*M samples per frame, next frame held off until the detector's done rises.
module dog_stream_tx
  import dog_pkg::*;
#(
  parameter int          N      = dog_pkg::N,
  parameter int          M      = dog_pkg::M,
  parameter int          PIX_W  = dog_pkg::PIX_W,
  parameter logic [15:0] OFFSET = dog_pkg::OFFSET
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] g0,
  input  logic [PIX_W-1:0] g1,
  input  logic [PIX_W-1:0] g2,
  input  logic [PIX_W-1:0] g3,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      Diff1,
  output logic [15:0]      Diff2,
  output logic [15:0]      Diff3,
  output logic             data_valid,
  input  logic             rx_done,
  output logic             frame_sent,
  output logic             busy
);

  localparam int                FRAME_PIX = N * M;
  localparam int                CNT_W     = $clog2(FRAME_PIX + 1);
  localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(FRAME_PIX - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FRAME_PIX);

  dog_state_e        r_state;
  dog_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_in_ready;
  logic              w_ready_nxt;
  logic              r_rx_done_p0;
  logic              w_rx_rise;
  logic              w_accept;
  logic              w_last;
  logic              w_frame_sent;

  logic [PIX_W-1:0]  r_g0_p0;
  logic [PIX_W-1:0]  r_g1_p0;
  logic [PIX_W-1:0]  r_g2_p0;
  logic [PIX_W-1:0]  r_g3_p0;
  logic              r_vld_p0;
  logic [2:0]        w_vld_p1;
  logic [2:0]        w_vld_p2;

  assign w_accept  = in_valid && r_in_ready;
  assign w_rx_rise = rx_done && !r_rx_done_p0;
  // Nothing new enters during DRAIN, so an empty pipe behind the output marks the last sample.
  assign w_last    = (r_state == ST_DRAIN) && w_vld_p2[0] && !w_vld_p1[0] && !r_vld_p0;

  // Stage 0: capture the four planes on accept so the lanes see stable operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g0_p0  <= '0;
      r_g1_p0  <= '0;
      r_g2_p0  <= '0;
      r_g3_p0  <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_accept;
      if (w_accept) begin
        r_g0_p0 <= g0;
        r_g1_p0 <= g1;
        r_g2_p0 <= g2;
        r_g3_p0 <= g3;
      end
    end
  end

  dog_sub_stage #(.PIX_W(PIX_W), .OFFSET(OFFSET)) u_diff1 (
    .clk(clk), .rst_n(rst_n), .i_vld(r_vld_p0), .i_a(r_g0_p0), .i_b(r_g1_p0),
    .o_vld_p1(w_vld_p1[0]), .o_vld_p2(w_vld_p2[0]), .o_diff(Diff1)
  );

  dog_sub_stage #(.PIX_W(PIX_W), .OFFSET(OFFSET)) u_diff2 (
    .clk(clk), .rst_n(rst_n), .i_vld(r_vld_p0), .i_a(r_g1_p0), .i_b(r_g2_p0),
    .o_vld_p1(w_vld_p1[1]), .o_vld_p2(w_vld_p2[1]), .o_diff(Diff2)
  );

  dog_sub_stage #(.PIX_W(PIX_W), .OFFSET(OFFSET)) u_diff3 (
    .clk(clk), .rst_n(rst_n), .i_vld(r_vld_p0), .i_a(r_g2_p0), .i_b(r_g3_p0),
    .o_vld_p1(w_vld_p1[2]), .o_vld_p2(w_vld_p2[2]), .o_diff(Diff3)
  );

  // The three lanes share one valid pipe; they must never disagree.
  a_lanes_lockstep: assert property (@(posedge clk) disable iff (!rst_n)
    ((&w_vld_p1) == (|w_vld_p1)) && ((&w_vld_p2) == (|w_vld_p2)));

  // Next-state, counter and ready logic for the frame sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_pix_cnt;
    w_frame_sent = 1'b0;
    w_ready_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = ONE_CNT;
          w_state_nxt = (ONE_CNT == FULL_CNT) ? ST_DRAIN : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_accept) begin
          w_cnt_nxt = r_pix_cnt + ONE_CNT;
          if (r_pix_cnt == LAST_CNT) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_last) begin
          w_frame_sent = 1'b1;
          w_state_nxt  = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (w_rx_rise) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    case (w_state_nxt)
      ST_IDLE:   w_ready_nxt = 1'b1;
      ST_STREAM: w_ready_nxt = (w_cnt_nxt < FULL_CNT);
      default:   w_ready_nxt = 1'b0;
    endcase
  end

  // Sequencer state, pixel count, registered ready and rx_done edge register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pix_cnt    <= '0;
      r_in_ready   <= 1'b0;
      r_rx_done_p0 <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pix_cnt    <= w_cnt_nxt;
      r_in_ready   <= w_ready_nxt;
      r_rx_done_p0 <= rx_done;
    end
  end

  assign in_ready   = r_in_ready;
  assign data_valid = w_vld_p2[0];
  assign frame_sent = w_frame_sent;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dog_stream_tx.sv
// Bench for dog_stream_tx with a 4x5 frame: vector table of pixels with hand-computed DoG
// outputs, a negedge scoreboard checking order/latency/values, and directed corner sequences.
module tb_dog_stream_tx;

  localparam int FRAME = 20;

  typedef struct {
    logic [7:0]  g0, g1, g2, g3;
    logic [15:0] d1, d2, d3;
  } vec_t;

  typedef struct {
    int idx;
    int eg;
  } acc_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  g0, g1, g2, g3;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Diff1, Diff2, Diff3;
  logic        data_valid;
  logic        rx_done;
  logic        frame_sent;
  logic        busy;

  vec_t tbl[FRAME];
  acc_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   edge_cnt = 0;
  int   out_cnt  = 0;
  int   sent_total = 0;
  int   drv_idx  = 0;
  int   lat_n;

  dog_stream_tx #(.N(4), .M(5), .PIX_W(8), .OFFSET(16'h8000)) dut (
    .clk(clk), .rst_n(rst_n), .g0(g0), .g1(g1), .g2(g2), .g3(g3),
    .in_valid(in_valid), .in_ready(in_ready), .Diff1(Diff1), .Diff2(Diff2), .Diff3(Diff3),
    .data_valid(data_valid), .rx_done(rx_done), .frame_sent(frame_sent), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    g0 = tbl[k].g0; g1 = tbl[k].g1; g2 = tbl[k].g2; g3 = tbl[k].g3;
    drv_idx = k;
  endtask

  // Scoreboard: outputs in order, two edges after their accept edge, values from the table.
  always @(negedge clk) begin
    acc_t e;
    if (!rst_n) begin
      exp_q.delete();
      out_cnt = 0;
    end else begin
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          chk("latency", edge_cnt, e.eg + 2);
          chk("diff1", Diff1, tbl[e.idx].d1);
          chk("diff2", Diff2, tbl[e.idx].d2);
          chk("diff3", Diff3, tbl[e.idx].d3);
        end
        out_cnt++;
      end
      if (frame_sent) begin
        chk("sent_count", out_cnt, FRAME);
        chk("sent_with_valid", data_valid, 1);
        out_cnt = 0;
        sent_total++;
      end
      if (in_valid && in_ready) exp_q.push_back('{idx: drv_idx, eg: edge_cnt + 1});
    end
  end

  // Send pixels start_k..19; mode 0 back-to-back, mode 1 in_valid toggling every cycle.
  task automatic run_frame(input int start_k, input int mode, input bit hold);
    int k;
    int cyc;
    bit acc;
    k = start_k;
    cyc = 0;
    while (k < FRAME && cyc < 200) begin
      drive(k);
      in_valid = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) k++;
    end
    if (k < FRAME) fail_now("frame_accept_timeout");
    chk("ready_after_last", in_ready, 0);
    if (hold) begin
      drive(0);
      in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_sent();
    lat_n = 0;
    while (!frame_sent && lat_n < 10) begin
      tick();
      lat_n++;
    end
    if (!frame_sent) fail_now("frame_sent_timeout");
    chk("sent_latency", lat_n, 2);
  endtask

  task automatic rx_pulse();
    tick();
    chk("wait_busy", busy, 1);
    chk("wait_ready", in_ready, 0);
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_ready", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{8'd10,  8'd20,  8'd20,  8'd5,   16'h800A, 16'h8000, 16'h7FF1};
    tbl[1]  = '{8'd0,   8'd255, 8'd0,   8'd255, 16'h80FF, 16'h7F01, 16'h80FF};
    tbl[2]  = '{8'd255, 8'd0,   8'd255, 8'd0,   16'h7F01, 16'h80FF, 16'h7F01};
    tbl[3]  = '{8'd0,   8'd0,   8'd0,   8'd0,   16'h8000, 16'h8000, 16'h8000};
    tbl[4]  = '{8'd255, 8'd255, 8'd255, 8'd255, 16'h8000, 16'h8000, 16'h8000};
    tbl[5]  = '{8'd1,   8'd2,   8'd4,   8'd8,   16'h8001, 16'h8002, 16'h8004};
    tbl[6]  = '{8'd8,   8'd4,   8'd2,   8'd1,   16'h7FFC, 16'h7FFE, 16'h7FFF};
    tbl[7]  = '{8'd100, 8'd50,  8'd150, 8'd200, 16'h7FCE, 16'h8064, 16'h8032};
    tbl[8]  = '{8'd128, 8'd127, 8'd129, 8'd128, 16'h7FFF, 16'h8002, 16'h7FFF};
    tbl[9]  = '{8'd0,   8'd128, 8'd255, 8'd1,   16'h8080, 16'h807F, 16'h7F02};
    tbl[10] = '{8'd50,  8'd60,  8'd70,  8'd80,  16'h800A, 16'h800A, 16'h800A};
    tbl[11] = '{8'd200, 8'd100, 8'd50,  8'd25,  16'h7F9C, 16'h7FCE, 16'h7FE7};
    tbl[12] = '{8'd17,  8'd34,  8'd51,  8'd68,  16'h8011, 16'h8011, 16'h8011};
    tbl[13] = '{8'd255, 8'd254, 8'd1,   8'd0,   16'h7FFF, 16'h7F03, 16'h7FFF};
    tbl[14] = '{8'd3,   8'd250, 8'd7,   8'd240, 16'h80F7, 16'h7F0D, 16'h80E9};
    tbl[15] = '{8'd90,  8'd90,  8'd91,  8'd89,  16'h8000, 16'h8001, 16'h7FFE};
    tbl[16] = '{8'd64,  8'd192, 8'd32,  8'd224, 16'h8080, 16'h7F60, 16'h80C0};
    tbl[17] = '{8'd5,   8'd0,   8'd10,  8'd0,   16'h7FFB, 16'h800A, 16'h7FF6};
    tbl[18] = '{8'd42,  8'd43,  8'd41,  8'd44,  16'h8001, 16'h7FFE, 16'h8003};
    tbl[19] = '{8'd99,  8'd1,   8'd200, 8'd2,   16'h7F9E, 16'h80C7, 16'h7F3A};

    rst_n = 1'b0; in_valid = 1'b0; rx_done = 1'b0;
    drive(0);

    // Reset values
    tick(); tick();
    chk("rst_diff1", Diff1, 0); chk("rst_diff2", Diff2, 0); chk("rst_diff3", Diff3, 0);
    chk("rst_dv", data_valid, 0); chk("rst_ready", in_ready, 0);
    chk("rst_sent", frame_sent, 0); chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready0", in_ready, 1);
    chk("idle_busy0", busy, 0);

    // Single pixel latency and values, then the rest of frame A back-to-back
    drive(0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_dv_e0", data_valid, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_dv_e1", data_valid, 0);
    tick();
    chk("t1_dv_e2", data_valid, 1);
    chk("t1_diff1", Diff1, 16'h800A);
    chk("t1_diff2", Diff2, 16'h8000);
    chk("t1_diff3", Diff3, 16'h7FF1);
    tick();
    chk("t1_dv_e3", data_valid, 0);
    chk("t1_hold1", Diff1, 16'h800A);
    chk("t1_hold3", Diff3, 16'h7FF1);
    run_frame(1, 0, 1'b0);
    wait_sent();
    rx_pulse();

    // Frame B back-to-back with in_valid held past the frame, then frame C starts at once
    run_frame(0, 0, 1'b1);
    wait_sent();
    rx_pulse();

    // Frame C with rx_done stuck high from IDLE onwards
    rx_done = 1'b1;
    run_frame(0, 0, 1'b0);
    wait_sent();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stuck_busy", busy, 1);
      chk("stuck_ready", in_ready, 0);
    end
    rx_done = 1'b0;
    tick();
    chk("drop_busy", busy, 1);
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    chk("rise_idle", busy, 0);

    // Frame D with in_valid toggling
    run_frame(0, 1, 1'b0);
    wait_sent();
    rx_pulse();

    // Reset after the 7th accept, then a clean full frame
    for (int k = 0; k < 7; k++) begin
      drive(k);
      in_valid = 1'b1;
      tick();
    end
    chk("pre_rst_dv", data_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dv", data_valid, 0);
    chk("arst_diff1", Diff1, 0); chk("arst_diff2", Diff2, 0); chk("arst_diff3", Diff3, 0);
    chk("arst_ready", in_ready, 0); chk("arst_sent", frame_sent, 0); chk("arst_busy", busy, 0);
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", in_ready, 1);
    run_frame(0, 0, 1'b0);
    wait_sent();
    rx_pulse();

    tick(); tick();
    chk("frames_sent", sent_total, 5);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
